dma_mem_arbiter: RTL and testbench
==================================

DMA_MEM_ARBITER -- requirements
Module: dma_mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 32, memory address width; DATA_WIDTH, 32, word width; BURST_LEN, 16, maximum DMA beats per locked burst; DMA_MAX_WAIT, 8, idle-state cycles DMA may be refused before it is forced ahead of CPU.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_WIDTH, cpu_wdata in DATA_WIDTH: single-beat CPU access request.
REQ-004 cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out DATA_WIDTH: CPU grant and read return.
REQ-005 dma_req in 1, dma_we in 1, dma_addr in ADDR_WIDTH, dma_wdata in DATA_WIDTH, dma_last in 1: DMA beat request; dma_last marks final beat of a line.
REQ-006 dma_gnt out 1, dma_rvalid out 1, dma_rdata out DATA_WIDTH: DMA grant and read return.
REQ-007 mem_en out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_rdata in DATA_WIDTH: shared single-port memory; mem_rdata valid one cycle after mem_en & !mem_we.
REQ-008 burst_err out 1: sticky flag, burst forcibly terminated.

Function
REQ-009 A beat SHALL transfer in any cycle where req & gnt for that requester; grants are combinational from state, counters and current requests.
REQ-010 At most one of cpu_gnt, dma_gnt SHALL be high in any cycle.
REQ-011 mem_en SHALL equal (cpu_req & cpu_gnt) | (dma_req & dma_gnt); mem_we/addr/wdata SHALL be muxed from the granted requester; mem_addr/wdata/we SHALL be 0 when mem_en=0.
REQ-012 States: IDLE, DMA_LOCK.
REQ-013 IDLE: if cpu_req and wait_cnt < DMA_MAX_WAIT -> cpu_gnt=1; else if dma_req -> dma_gnt=1.
REQ-014 IDLE: wait_cnt SHALL increment (saturating at DMA_MAX_WAIT) each cycle dma_req=1 and dma_gnt=0; SHALL clear on any granted DMA beat.
REQ-015 IDLE -> DMA_LOCK on a granted DMA beat with dma_last=0; beat_cnt <= 1. A granted beat with dma_last=1 SHALL remain in IDLE.
REQ-016 DMA_LOCK: cpu_gnt=0; dma_gnt=dma_req; each granted beat increments beat_cnt.
REQ-017 DMA_LOCK with dma_req=0 SHALL hold the lock (mem_en=0, no timeout).
REQ-018 DMA_LOCK -> IDLE on a granted beat with dma_last=1; beat_cnt <= 0.
REQ-019 DMA_LOCK -> IDLE on the granted beat that makes beat_cnt = BURST_LEN with dma_last=0; burst_err <= 1 (sticky until reset).
REQ-020 First cycle after DMA_LOCK -> IDLE, CPU SHALL win if requesting (REQ-013 applies unchanged).
REQ-021 cpu_rvalid SHALL be 1 exactly one cycle after a granted CPU read beat; dma_rvalid likewise for DMA; a write beat SHALL produce no rvalid.
REQ-022 cpu_rdata and dma_rdata SHALL both pass mem_rdata through combinationally; only the matching rvalid qualifies it.
REQ-023 beat_cnt width SHALL be $clog2(BURST_LEN)+1; wait_cnt width $clog2(DMA_MAX_WAIT)+1; no wrap.

Reset
REQ-024 On rst_n low (asynchronous): state=IDLE, beat_cnt=0, wait_cnt=0, burst_err=0, cpu_rvalid=0, dma_rvalid=0; grants and mem_en evaluate to IDLE values; any in-flight read return SHALL be discarded.
REQ-025 Reset asserted mid-burst SHALL release the lock; after release, CPU requests SHALL be granted in the first cycle.

Verification
REQ-026 CPU and DMA both request continuously from reset -> CPU granted cycles 0-7, DMA granted cycle 8 (wait_cnt=8), wait_cnt cleared.
REQ-027 DMA 16-beat line, dma_last on beat 16, cpu_req held high -> dma_gnt on all 16 beats, cpu_gnt=0 throughout, cpu_gnt=1 next cycle, burst_err=0.
REQ-028 DMA 17 beats with dma_last never set -> lock released after beat 16, burst_err=1, CPU granted next cycle, flag persists until reset.
REQ-029 CPU read addr 0x5000 with mem_rdata=0xDEADBEEF next cycle -> cpu_rvalid=1 for one cycle, cpu_rdata=0xDEADBEEF, dma_rvalid=0.
REQ-030 rst_n pulsed low during DMA beat 5 of a read burst -> dma_rvalid=0 following cycle, state IDLE, lone CPU request granted immediately after release.
REQ-031 DMA lock with dma_req dropped for 3 cycles -> mem_en=0 and cpu_gnt=0 those cycles, burst resumes with beat_cnt continuing.

Source files
------------

// File: rtl/dma_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dma_mem_arbiter
//
// Arbitrates a single-port memory between a CPU (single-beat accesses) and a
// DMA engine (multi-beat lines). In IDLE the CPU has priority unless the DMA
// has been refused DMA_MAX_WAIT times in a row. A DMA beat without dma_last
// locks the memory to the DMA until the line ends or BURST_LEN beats have
// been moved. Hitting BURST_LEN without dma_last sets the sticky burst_err
// flag and releases the lock.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU single-beat request
//   cpu_gnt, cpu_rvalid, cpu_rdata  CPU grant and read return
//   dma_req/we/addr/wdata/last      DMA beat request, last beat of a line
//   dma_gnt, dma_rvalid, dma_rdata  DMA grant and read return
//   mem_en/we/addr/wdata, mem_rdata shared memory port (1-cycle read latency)
//   burst_err                       sticky: a burst was forcibly terminated
// -----------------------------------------------------------------------------
module dma_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 16,
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,

  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  input  logic                  dma_last,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  burst_err
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int WW = $clog2(DMA_MAX_WAIT) + 1;

  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(BURST_LEN);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(DMA_MAX_WAIT);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DMA_LOCK = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_cnt, beat_cnt_nxt, beat_cnt_inc;
  logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            burst_err_nxt;
  logic            cpu_beat, dma_beat;

  // ---------------------------------------------------------------------------
  // Grants: purely combinational from state, counters and live requests.
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // CPU wins unless the DMA has been starved long enough.
        if (cpu_req && (wait_cnt < WAIT_MAX)) begin
          cpu_gnt = 1'b1;
        end else if (dma_req) begin
          dma_gnt = 1'b1;
        end
      end
      ST_DMA_LOCK: begin
        // Lock holds even while dma_req is low; the CPU stays locked out.
        dma_gnt = dma_req;
      end
      default: ;
    endcase
  end

  assign cpu_beat = cpu_req & cpu_gnt;
  assign dma_beat = dma_req & dma_gnt;

  // ---------------------------------------------------------------------------
  // Memory port mux; all command fields are forced to zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = cpu_beat | dma_beat;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_beat) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_beat) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Read data is shared; the per-requester rvalid says whose it is.
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  // ---------------------------------------------------------------------------
  // Next-state, counters and error flag.
  // ---------------------------------------------------------------------------
  assign beat_cnt_inc = beat_cnt + BEAT_ONE;

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    wait_cnt_nxt  = wait_cnt;
    burst_err_nxt = burst_err;

    // Starvation counter: only moves while the DMA is asking and refused.
    if (dma_beat) begin
      wait_cnt_nxt = '0;
    end else if (dma_req && !dma_gnt && (wait_cnt < WAIT_MAX)) begin
      wait_cnt_nxt = wait_cnt + WAIT_ONE;
    end

    unique case (state)
      ST_IDLE: begin
        // A single-beat line (dma_last on the first beat) never locks.
        if (dma_beat && !dma_last) begin
          state_nxt    = ST_DMA_LOCK;
          beat_cnt_nxt = BEAT_ONE;
        end
      end
      ST_DMA_LOCK: begin
        if (dma_beat) begin
          if (dma_last) begin
            state_nxt    = ST_IDLE;
            beat_cnt_nxt = '0;
          end else if (beat_cnt_inc == BEAT_MAX) begin
            // Runaway line: cut it off and flag it.
            state_nxt     = ST_IDLE;
            beat_cnt_nxt  = '0;
            burst_err_nxt = 1'b1;
          end else begin
            beat_cnt_nxt = beat_cnt_inc;
          end
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      burst_err  <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      burst_err  <= burst_err_nxt;
      cpu_rvalid <= cpu_beat & ~cpu_we;
      dma_rvalid <= dma_beat & ~dma_we;
    end
  end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_mem_arbiter
//
// Directed bench for dma_mem_arbiter with default parameters
// (BURST_LEN = 16, DMA_MAX_WAIT = 8). Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dma_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req, dma_we, dma_last;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;

  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        burst_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_last   (dma_last),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .burst_err  (burst_err)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = 32'h0;
    dma_wdata = 32'h0;
    dma_last  = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released 1 ns after a rising edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reset values
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid: got %b expected 0", cpu_rvalid); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid: got %b expected 0", dma_rvalid); end
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL reset_burst_err: got %b expected 0", burst_err); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if ({cpu_gnt, dma_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnts: got %b expected 00", {cpu_gnt, dma_gnt}); end
    do_reset();
    // First cycle out of reset: a lone CPU request is granted at once.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL reset_first_cpu_gnt: got %b expected 1", cpu_gnt); end
    step();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Starvation guard: both request continuously from reset
  // ---------------------------------------------------------------------------
  task automatic test_arbitration();
    logic exp_cpu;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0C0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'hD0D0;
    dma_last = 1'b1;
    for (int i = 0; i < 19; i++) begin
      // DMA wins when wait_cnt reaches 8: cycle 8, then again 9 cycles later.
      exp_cpu = !(i == 8 || i == 17);
      @(negedge clk);
      checks++; if (cpu_gnt !== exp_cpu) begin errors++; $display("FAIL arb_cpu_gnt cycle %0d: got %b expected %b", i, cpu_gnt, exp_cpu); end
      checks++; if (dma_gnt !== !exp_cpu) begin errors++; $display("FAIL arb_dma_gnt cycle %0d: got %b expected %b", i, dma_gnt, !exp_cpu); end
      if (i == 7 || i == 8) begin
        checks++; if (mem_addr !== (exp_cpu ? 32'h100 : 32'h200)) begin errors++; $display("FAIL arb_mem_addr cycle %0d: got %h expected %h", i, mem_addr, exp_cpu ? 32'h100 : 32'h200); end
        checks++; if (mem_wdata !== (exp_cpu ? 32'hC0C0 : 32'hD0D0)) begin errors++; $display("FAIL arb_mem_wdata cycle %0d: got %h expected %h", i, mem_wdata, exp_cpu ? 32'hC0C0 : 32'hD0D0); end
        checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL arb_mem_en_we cycle %0d: got %b expected 11", i, {mem_en, mem_we}); end
      end
      step();
    end
    // No requests: command fields must be zero.
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 66'h0) begin errors++; $display("FAIL arb_idle_zero: got en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    step();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // 16-beat DMA line with cpu_req held high throughout
  // ---------------------------------------------------------------------------
  task automatic test_dma_line();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b0;
    repeat (8) step();   // CPU wins while wait_cnt climbs to 8
    for (int b = 1; b <= 16; b++) begin
      dma_addr = 32'h1000 + 32'(b);
      dma_last = (b == 16);
      @(negedge clk);
      checks++; if ({dma_gnt, cpu_gnt} !== 2'b10) begin errors++; $display("FAIL line_gnt beat %0d: got dma,cpu=%b expected 10", b, {dma_gnt, cpu_gnt}); end
      if (b == 16) begin
        checks++; if (mem_addr !== 32'h1010) begin errors++; $display("FAIL line_mem_addr beat 16: got %h expected 00001010", mem_addr); end
      end
      step();
    end
    // DMA still asking, but the CPU wins the first cycle after the line.
    dma_last = 1'b0;
    @(negedge clk);
    checks++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin errors++; $display("FAIL line_after_gnt: got cpu,dma=%b expected 10", {cpu_gnt, dma_gnt}); end
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL line_burst_err: got %b expected 0", burst_err); end
    step();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Runaway DMA: 17 beats, dma_last never set
  // ---------------------------------------------------------------------------
  task automatic test_burst_overrun();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b0;
    repeat (8) step();
    for (int b = 1; b <= 16; b++) begin
      @(negedge clk);
      checks++; if ({dma_gnt, cpu_gnt} !== 2'b10) begin errors++; $display("FAIL overrun_gnt beat %0d: got dma,cpu=%b expected 10", b, {dma_gnt, cpu_gnt}); end
      if (b == 16) begin
        checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL overrun_err_early: got %b expected 0", burst_err); end
      end
      step();
    end
    // Beat 17 is refused: lock released, CPU wins.
    @(negedge clk);
    checks++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin errors++; $display("FAIL overrun_release: got cpu,dma=%b expected 10", {cpu_gnt, dma_gnt}); end
    checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL overrun_err_set: got %b expected 1", burst_err); end
    step();
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (3) step();
    // A clean single-beat line does not clear the flag.
    dma_req = 1'b1; dma_last = 1'b1;
    step();
    dma_req = 1'b0; dma_last = 1'b0;
    @(negedge clk);
    checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL overrun_err_sticky: got %b expected 1", burst_err); end
    do_reset();
    @(negedge clk);
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL overrun_err_reset: got %b expected 0", burst_err); end
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Read returns and write (no return)
  // ---------------------------------------------------------------------------
  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h5000}) begin errors++; $display("FAIL rd_mem_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=00005000", mem_en, mem_we, mem_addr); end
    step();
    cpu_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_cpu_rvalid: got %b expected 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_cpu_rdata: got %h expected deadbeef", cpu_rdata); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_dma_rvalid: got %b expected 0", dma_rvalid); end
    step();
    // Next cycle: pulse is over. Also issue a CPU write.
    mem_rdata = 32'h0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h5004;
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_cpu_rvalid_pulse: got %b expected 0", cpu_rvalid); end
    step();
    cpu_req = 1'b0;
    // Single-beat DMA read in the same cycle the write would have returned.
    dma_req = 1'b1; dma_we = 1'b0; dma_last = 1'b1; dma_addr = 32'h6000;
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid); end
    step();
    dma_req = 1'b0; dma_last = 1'b0; mem_rdata = 32'h12345678;
    @(negedge clk);
    checks++; if ({dma_rvalid, cpu_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_dma_rvalid_1: got dma,cpu=%b expected 10", {dma_rvalid, cpu_rvalid}); end
    checks++; if (dma_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_dma_rdata: got %h expected 12345678", dma_rdata); end
    step();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Reset pulse during beat 5 of a DMA read burst
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_burst();
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_last = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      dma_addr = 32'h300 + 32'(b);
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_dma_gnt beat %0d: got %b expected 1", b, dma_gnt); end
      if (b >= 2) begin
        checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_dma_rvalid beat %0d: got %b expected 1", b, dma_rvalid); end
      end
      if (b == 5) begin
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_async_clear: got %b expected 0", dma_rvalid); end
      end
      step();
    end
    rst_n = 1'b1;
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h77;
    @(negedge clk);
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_read_discarded: got %b expected 0", dma_rvalid); end
    checks++; if ({cpu_gnt, mem_en} !== 2'b11) begin errors++; $display("FAIL rstmid_cpu_gnt: got gnt,en=%b expected 11", {cpu_gnt, mem_en}); end
    step();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Lock held across a 3-cycle DMA pause; beat count continues afterwards
  // ---------------------------------------------------------------------------
  task automatic test_lock_pause();
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL pause_pre_gnt beat %0d: got %b expected 1", b, dma_gnt); end
      step();
    end
    dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({mem_en, cpu_gnt, dma_gnt} !== 3'b000) begin errors++; $display("FAIL pause_hold cycle %0d: got en,cpu,dma=%b expected 000", c, {mem_en, cpu_gnt, dma_gnt}); end
      step();
    end
    dma_req = 1'b1;
    // Beats 4..16: the 16th beat ends the burst because the count kept going.
    for (int b = 4; b <= 16; b++) begin
      @(negedge clk);
      checks++; if ({dma_gnt, cpu_gnt, mem_en} !== 3'b101) begin errors++; $display("FAIL pause_resume beat %0d: got dma,cpu,en=%b expected 101", b, {dma_gnt, cpu_gnt, mem_en}); end
      step();
    end
    @(negedge clk);
    checks++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin errors++; $display("FAIL pause_release: got cpu,dma=%b expected 10", {cpu_gnt, dma_gnt}); end
    checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL pause_burst_err: got %b expected 1", burst_err); end
    step();
    idle_inputs();
  endtask

  // One-hot grant invariant, checked on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (cpu_gnt === 1'b1 && dma_gnt === 1'b1) begin
        errors++;
        $display("FAIL gnt_onehot at %0t: got cpu_gnt=1 dma_gnt=1 expected at most one", $time);
      end
    end
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_arbitration();
    test_dma_line();
    test_burst_overrun();
    test_cpu_read();
    test_reset_mid_burst();
    test_lock_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
